load_v_stream: RTL and testbench

- Parametrised successor vector loader: fetches `length` elements from DRAM starting at `dram_addr` over a multi-element-wide memory bus.
- Packs elements into TILE_ELEMS-wide tiles and streams tiles to the consumer under ready/valid backpressure.
- Zero-pads the final partial tile and issues no reads for beats wholly past `length`.
- Sits between the instruction decoder / load unit and the vector/tile buffers.

---
 rtl/load_pkg.sv | 22 ++
 rtl/load_lane_mask.sv | 18 +
 rtl/load_v_stream.sv | 189 ++++++++++++++++++
 tb/tb_load_v_stream.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_pkg.sv
// Shared types and helpers for the vector-stream loader: FSM state encoding,
// default geometry and the tile-count calculation.
package load_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } load_state_e;

    localparam int TILE_ELEMS_DEF = 32;
    localparam int BUS_ELEMS_DEF  = 4;
    localparam int BEATS_PER_TILE = TILE_ELEMS_DEF / BUS_ELEMS_DEF;

    // Number of tiles needed to hold len elements (ceiling division).
    function automatic logic [31:0] tile_count(input logic [31:0] len,
                                               input int unsigned tile_elems);
        return (len + 32'(tile_elems) - 32'd1) / 32'(tile_elems);
    endfunction

endpackage

// File: rtl/load_lane_mask.sv
// Marks which lanes of the current memory beat still fall inside the
// requested element range; lanes past the end are zero-filled by the loader.
module load_lane_mask #(
    parameter int BUS_ELEMS = 4,
    parameter int LEN_WIDTH = 16
) (
    input  logic [LEN_WIDTH:0]   elem_idx,
    input  logic [LEN_WIDTH-1:0] len,
    output logic [BUS_ELEMS-1:0] lane_mask
);

    // One extra bit of headroom so elem_idx + lane never wraps.
    for (genvar i = 0; i < BUS_ELEMS; i++) begin : g_lane
        assign lane_mask[i] = ((LEN_WIDTH+2)'(elem_idx) + (LEN_WIDTH+2)'(i))
                              < (LEN_WIDTH+2)'(len);
    end

endmodule

// File: rtl/load_v_stream.sv
// Vector loader: reads `length` elements from DRAM beat by beat, packs them
// into zero-padded tiles and streams the tiles out under ready/valid.
// Optional performance counters are enabled with LOAD_V_STREAM_PERF_EN.
module load_v_stream
    import load_pkg::*;
#(
    parameter int TILE_ELEMS = TILE_ELEMS_DEF,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 24,
    parameter int BUS_ELEMS  = BUS_ELEMS_DEF,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          valid_in,
    input  logic [ADDR_WIDTH-1:0]         dram_addr,
    input  logic [LEN_WIDTH-1:0]          length,
    output logic                          busy,
    output logic                          mem_req,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    input  logic [BUS_ELEMS*DATA_WIDTH-1:0] mem_rdata,
    input  logic                          mem_valid,
    output logic [DATA_WIDTH-1:0]         tile_data [TILE_ELEMS],
    output logic                          tile_valid,
    input  logic                          tile_ready,
    output logic                          tile_last,
    output logic [LEN_WIDTH-1:0]          tile_idx,
    output logic                          done
`ifdef LOAD_V_STREAM_PERF_EN
    ,
    output logic [31:0]                   perf_mem_wait,
    output logic [31:0]                   perf_bp_stall
`endif
);

    localparam int BEATS  = TILE_ELEMS / BUS_ELEMS;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (TILE_ELEMS % BUS_ELEMS != 0) begin : g_bad_geometry
        $error("load_v_stream: TILE_ELEMS must be a multiple of BUS_ELEMS");
    end

    load_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [LEN_WIDTH-1:0]    len_q, len_d;
    logic [LEN_WIDTH:0]      elem_idx_q, elem_idx_d;
    logic [BEAT_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic [LEN_WIDTH-1:0]    tile_idx_q, tile_idx_d;
    logic [LEN_WIDTH-1:0]    tiles_q, tiles_d;
    logic [DATA_WIDTH-1:0]   tile_buf_q [TILE_ELEMS];
    logic [DATA_WIDTH-1:0]   tile_buf_d [TILE_ELEMS];
    logic [BUS_ELEMS-1:0]    lane_mask;
    logic [LEN_WIDTH:0]      elem_next;
    logic                    is_last_tile;

    load_lane_mask #(
        .BUS_ELEMS (BUS_ELEMS),
        .LEN_WIDTH (LEN_WIDTH)
    ) u_lane_mask (
        .elem_idx  (elem_idx_q),
        .len       (len_q),
        .lane_mask (lane_mask)
    );

    assign elem_next    = elem_idx_q + (LEN_WIDTH+1)'(BUS_ELEMS);
    assign is_last_tile = (tile_idx_q == tiles_q - 1'b1);

    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        len_d      = len_q;
        elem_idx_d = elem_idx_q;
        beat_cnt_d = beat_cnt_q;
        tile_idx_d = tile_idx_q;
        tiles_d    = tiles_q;
        tile_buf_d = tile_buf_q;
        busy       = (state_q != IDLE);
        mem_req    = 1'b0;
        tile_valid = 1'b0;
        tile_last  = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (valid_in) begin
                    len_d      = length;
                    tiles_d    = LEN_WIDTH'(tile_count(32'(length), TILE_ELEMS));
                    mem_addr_d = dram_addr;
                    elem_idx_d = '0;
                    beat_cnt_d = '0;
                    tile_idx_d = '0;
                    for (int j = 0; j < TILE_ELEMS; j++) tile_buf_d[j] = '0;
                    state_d    = (length == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                mem_req = 1'b1;
                if (mem_valid) begin
                    // Lanes beyond the end of the vector are written as zero.
                    for (int j = 0; j < TILE_ELEMS; j++) begin
                        if (int'(beat_cnt_q) == j / BUS_ELEMS) begin
                            tile_buf_d[j] = lane_mask[j % BUS_ELEMS]
                                ? mem_rdata[(j % BUS_ELEMS)*DATA_WIDTH +: DATA_WIDTH]
                                : '0;
                        end
                    end
                    elem_idx_d = elem_next;
                    mem_addr_d = mem_addr_q + ADDR_WIDTH'(BUS_ELEMS);
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == BEAT_W'(BEATS - 1) || elem_next >= {1'b0, len_q}) begin
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                tile_valid = 1'b1;
                tile_last  = is_last_tile;
                if (tile_ready) begin
                    if (is_last_tile) begin
                        state_d = DONE;
                    end else begin
                        beat_cnt_d = '0;
                        tile_idx_d = tile_idx_q + 1'b1;
                        for (int j = 0; j < TILE_ELEMS; j++) tile_buf_d[j] = '0;
                        state_d    = FILL;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mem_addr_q <= '0;
            len_q      <= '0;
            elem_idx_q <= '0;
            beat_cnt_q <= '0;
            tile_idx_q <= '0;
            tiles_q    <= '0;
            for (int j = 0; j < TILE_ELEMS; j++) tile_buf_q[j] <= '0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            len_q      <= len_d;
            elem_idx_q <= elem_idx_d;
            beat_cnt_q <= beat_cnt_d;
            tile_idx_q <= tile_idx_d;
            tiles_q    <= tiles_d;
            tile_buf_q <= tile_buf_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign tile_idx  = tile_idx_q;
    assign tile_data = tile_buf_q;

`ifdef LOAD_V_STREAM_PERF_EN
    logic        accept;
    logic [31:0] perf_mem_wait_q;
    logic [31:0] perf_bp_stall_q;

    assign accept = (state_q == IDLE) && valid_in;

    // Saturating stall counters, restarted by every accepted command.
    always_ff @(posedge clk) begin
        if (!rst_n || accept) begin
            perf_mem_wait_q <= '0;
            perf_bp_stall_q <= '0;
        end else begin
            if (state_q == FILL && !mem_valid && perf_mem_wait_q != '1) begin
                perf_mem_wait_q <= perf_mem_wait_q + 32'd1;
            end
            if (state_q == EMIT && !tile_ready && perf_bp_stall_q != '1) begin
                perf_bp_stall_q <= perf_bp_stall_q + 32'd1;
            end
        end
    end

    assign perf_mem_wait = perf_mem_wait_q;
    assign perf_bp_stall = perf_bp_stall_q;
`endif

endmodule

// File: tb/tb_load_v_stream.sv
// Directed self-checking bench for load_v_stream; memory returns the low
// byte of each element address so tile contents are predictable.
module tb_load_v_stream;
    import load_pkg::*;

    localparam int TE = 32;
    localparam int DW = 8;
    localparam int AW = 24;
    localparam int BE = 4;
    localparam int LW = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           valid_in = 1'b0;
    logic [AW-1:0]  dram_addr = '0;
    logic [LW-1:0]  length = '0;
    logic           busy;
    logic           mem_req;
    logic [AW-1:0]  mem_addr;
    logic [BE*DW-1:0] mem_rdata;
    logic           mem_valid = 1'b0;
    logic [DW-1:0]  tile_data [TE];
    logic           tile_valid;
    logic           tile_ready = 1'b1;
    logic           tile_last;
    logic [LW-1:0]  tile_idx;
    logic           done;
`ifdef LOAD_V_STREAM_PERF_EN
    logic [31:0]    perf_mem_wait;
    logic [31:0]    perf_bp_stall;
`endif

    int checks = 0;
    int errors = 0;

    logic [AW-1:0]    reqQ [$];
    logic [TE*DW-1:0] tileQ [$];
    logic             lastQ [$];
    logic [LW-1:0]    idxQ [$];
    int firstReqCyc, reqCycles, firstTileCyc, doneCyc, stabErr, memWaitCyc;

    load_v_stream dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (valid_in),
        .dram_addr  (dram_addr),
        .length     (length),
        .busy       (busy),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_valid  (mem_valid),
        .tile_data  (tile_data),
        .tile_valid (tile_valid),
        .tile_ready (tile_ready),
        .tile_last  (tile_last),
        .tile_idx   (tile_idx),
        .done       (done)
`ifdef LOAD_V_STREAM_PERF_EN
        ,
        .perf_mem_wait (perf_mem_wait),
        .perf_bp_stall (perf_bp_stall)
`endif
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < BE; i++) mem_rdata[i*DW +: DW] = 8'(mem_addr + AW'(i));
    end

    function automatic logic [TE*DW-1:0] flatten();
        logic [TE*DW-1:0] f;
        for (int i = 0; i < TE; i++) f[i*DW +: DW] = tile_data[i];
        return f;
    endfunction

    // Expected tile: n elements starting at address base, rest zero.
    function automatic logic [TE*DW-1:0] expTile(input logic [AW-1:0] base, input int n);
        logic [TE*DW-1:0] e;
        for (int i = 0; i < TE; i++) e[i*DW +: DW] = (i < n) ? 8'(base + AW'(i)) : 8'h00;
        return e;
    endfunction

    // Drives one command and records requests/tiles until done or maxCyc.
    task automatic runTransfer(input logic [AW-1:0] addr, input logic [LW-1:0] len,
                               input int gapMode, input int stall, input int maxCyc);
        int stallLeft;
        logic prevReq, prevMv, prevStalled;
        logic [AW-1:0] prevAddr;
        logic [TE*DW-1:0] prevData;
        logic [LW-1:0] prevIdx;
        reqQ.delete(); tileQ.delete(); lastQ.delete(); idxQ.delete();
        firstReqCyc = -1; reqCycles = 0; firstTileCyc = -1; doneCyc = -1;
        stabErr = 0; memWaitCyc = 0; stallLeft = stall;
        prevReq = 0; prevMv = 0; prevStalled = 0; prevAddr = '0; prevData = '0; prevIdx = '0;
        @(posedge clk); #1;
        valid_in = 1'b1; dram_addr = addr; length = len;
        mem_valid = (gapMode == 0); tile_ready = 1'b1;
        for (int cyc = 1; cyc <= maxCyc && doneCyc < 0; cyc++) begin
            @(posedge clk); #1;
            valid_in = 1'b0;
            mem_valid = (gapMode == 0) ? 1'b1 : ((cyc % 3) != 2);
            if (tile_valid && stallLeft > 0) begin
                tile_ready = 1'b0;
                stallLeft--;
            end else begin
                tile_ready = 1'b1;
            end
            @(negedge clk);
            if (mem_req) begin
                reqCycles++;
                if (firstReqCyc < 0) firstReqCyc = cyc;
                if (!mem_valid) memWaitCyc++;
                if (prevReq && !prevMv && mem_addr !== prevAddr) stabErr++;
                if (mem_valid) reqQ.push_back(mem_addr);
            end
            if (tile_valid) begin
                if (firstTileCyc < 0) firstTileCyc = cyc;
                if (prevStalled && (flatten() !== prevData || tile_idx !== prevIdx)) stabErr++;
                if (tile_ready) begin
                    tileQ.push_back(flatten());
                    lastQ.push_back(tile_last);
                    idxQ.push_back(tile_idx);
                end
            end
            if (done) doneCyc = cyc;
            prevReq = mem_req; prevMv = mem_valid; prevAddr = mem_addr;
            prevStalled = tile_valid && !tile_ready;
            prevData = flatten(); prevIdx = tile_idx;
        end
        mem_valid = 1'b0; tile_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset.busy got %b want 0", busy); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset.mem_req got %b want 0", mem_req); end
        checks++; if (mem_addr !== '0) begin errors++; $display("[TB] FAIL reset.mem_addr got %h want 0", mem_addr); end
        checks++; if (tile_valid !== 1'b0 || tile_last !== 1'b0 || done !== 1'b0) begin
            errors++; $display("[TB] FAIL reset.flags got v=%b l=%b d=%b want 0", tile_valid, tile_last, done); end
        checks++; if (tile_idx !== '0) begin errors++; $display("[TB] FAIL reset.tile_idx got %0d want 0", tile_idx); end
        checks++; if (flatten() !== '0) begin errors++; $display("[TB] FAIL reset.tile_data got %h want 0", flatten()); end
`ifdef LOAD_V_STREAM_PERF_EN
        checks++; if (perf_mem_wait !== 0 || perf_bp_stall !== 0) begin
            errors++; $display("[TB] FAIL reset.perf got %0d/%0d want 0/0", perf_mem_wait, perf_bp_stall); end
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single_tile();
        runTransfer(24'h000100, 16'd32, 0, 0, 50);
        checks++; if (reqQ.size() != BEATS_PER_TILE) begin errors++; $display("[TB] FAIL single.req_count got %0d want %0d", reqQ.size(), BEATS_PER_TILE); end
        for (int k = 0; k < reqQ.size(); k++) begin
            checks++; if (reqQ[k] !== 24'h000100 + AW'(4*k)) begin
                errors++; $display("[TB] FAIL single.req_addr[%0d] got %h want %h", k, reqQ[k], 24'h000100 + AW'(4*k)); end
        end
        checks++; if (firstReqCyc != 1 || reqCycles != 8) begin errors++; $display("[TB] FAIL single.req_timing got first=%0d n=%0d want 1/8", firstReqCyc, reqCycles); end
        checks++; if (firstTileCyc != 9) begin errors++; $display("[TB] FAIL single.tile_cycle got %0d want 9", firstTileCyc); end
        checks++; if (doneCyc != 10) begin errors++; $display("[TB] FAIL single.done_cycle got %0d want 10", doneCyc); end
        checks++; if (tileQ.size() != 1) begin errors++; $display("[TB] FAIL single.tile_count got %0d want 1", tileQ.size()); end
        if (tileQ.size() > 0) begin
            checks++; if (tileQ[0] !== expTile(24'h000100, 32)) begin errors++; $display("[TB] FAIL single.tile_data got %h want %h", tileQ[0], expTile(24'h000100, 32)); end
            checks++; if (lastQ[0] !== 1'b1 || idxQ[0] !== '0) begin errors++; $display("[TB] FAIL single.last_idx got %b/%0d want 1/0", lastQ[0], idxQ[0]); end
        end
    endtask

    task automatic test_partial_tile();
        bit hit28;
        runTransfer(24'h000000, 16'd37, 0, 0, 60);
        hit28 = 0;
        foreach (reqQ[k]) if (reqQ[k] == 24'h000028) hit28 = 1;
        checks++; if (reqQ.size() != 10 || reqCycles != 10) begin errors++; $display("[TB] FAIL partial.req_count got %0d/%0d want 10", reqQ.size(), reqCycles); end
        checks++; if (hit28) begin errors++; $display("[TB] FAIL partial.req_0x28 got 1 want 0"); end
        checks++; if (doneCyc < 0) begin errors++; $display("[TB] FAIL partial.timeout got %0d want done", doneCyc); end
        checks++; if (tileQ.size() != 2) begin errors++; $display("[TB] FAIL partial.tile_count got %0d want 2", tileQ.size()); end
        if (tileQ.size() == 2) begin
            checks++; if (tileQ[0] !== expTile(24'h000000, 32)) begin errors++; $display("[TB] FAIL partial.tile0 got %h want %h", tileQ[0], expTile(24'h000000, 32)); end
            checks++; if (tileQ[1] !== expTile(24'h000020, 5)) begin errors++; $display("[TB] FAIL partial.tile1 got %h want %h", tileQ[1], expTile(24'h000020, 5)); end
            checks++; if (lastQ[0] !== 1'b0 || lastQ[1] !== 1'b1) begin errors++; $display("[TB] FAIL partial.last got %b%b want 01", lastQ[0], lastQ[1]); end
            checks++; if (idxQ[0] !== 16'd0 || idxQ[1] !== 16'd1) begin errors++; $display("[TB] FAIL partial.idx got %0d,%0d want 0,1", idxQ[0], idxQ[1]); end
        end
    endtask

    task automatic test_zero_length();
        runTransfer(24'h000123, 16'd0, 0, 0, 20);
        checks++; if (reqCycles != 0) begin errors++; $display("[TB] FAIL zero.mem_req got %0d want 0", reqCycles); end
        checks++; if (firstTileCyc != -1) begin errors++; $display("[TB] FAIL zero.tile_valid got %0d want -1", firstTileCyc); end
        checks++; if (doneCyc != 1) begin errors++; $display("[TB] FAIL zero.done_cycle got %0d want 1", doneCyc); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL zero.after got done=%b busy=%b want 0/0", done, busy); end
    endtask

    task automatic test_backpressure();
        int seqErr;
        runTransfer(24'h000040, 16'd64, 1, 5, 400);
        seqErr = 0;
        foreach (reqQ[k]) if (reqQ[k] !== 24'h000040 + AW'(4*k)) seqErr++;
        checks++; if (reqQ.size() != 16 || seqErr != 0) begin errors++; $display("[TB] FAIL bp.requests got n=%0d bad=%0d want 16/0", reqQ.size(), seqErr); end
        checks++; if (stabErr != 0) begin errors++; $display("[TB] FAIL bp.stability got %0d want 0", stabErr); end
        checks++; if (doneCyc < 0) begin errors++; $display("[TB] FAIL bp.timeout got %0d want done", doneCyc); end
        checks++; if (tileQ.size() != 2) begin errors++; $display("[TB] FAIL bp.tile_count got %0d want 2", tileQ.size()); end
        if (tileQ.size() == 2) begin
            checks++; if (tileQ[0] !== expTile(24'h000040, 32)) begin errors++; $display("[TB] FAIL bp.tile0 got %h want %h", tileQ[0], expTile(24'h000040, 32)); end
            checks++; if (tileQ[1] !== expTile(24'h000060, 32)) begin errors++; $display("[TB] FAIL bp.tile1 got %h want %h", tileQ[1], expTile(24'h000060, 32)); end
            checks++; if (idxQ[1] !== 16'd1 || lastQ[1] !== 1'b1 || lastQ[0] !== 1'b0) begin errors++; $display("[TB] FAIL bp.idx_last got %0d %b%b want 1 01", idxQ[1], lastQ[0], lastQ[1]); end
        end
`ifdef LOAD_V_STREAM_PERF_EN
        checks++; if (perf_bp_stall !== 32'd5) begin errors++; $display("[TB] FAIL bp.perf_bp_stall got %0d want 5", perf_bp_stall); end
        checks++; if (perf_mem_wait !== 32'(memWaitCyc)) begin errors++; $display("[TB] FAIL bp.perf_mem_wait got %0d want %0d", perf_mem_wait, memWaitCyc); end
`endif
    endtask

    task automatic test_addr_wrap();
        runTransfer(24'hFFFFFC, 16'd8, 0, 0, 40);
        checks++; if (reqQ.size() != 2) begin errors++; $display("[TB] FAIL wrap.req_count got %0d want 2", reqQ.size()); end
        if (reqQ.size() == 2) begin
            checks++; if (reqQ[0] !== 24'hFFFFFC || reqQ[1] !== 24'h000000) begin errors++; $display("[TB] FAIL wrap.addr got %h,%h want fffffc,000000", reqQ[0], reqQ[1]); end
        end
        checks++; if (tileQ.size() != 1) begin errors++; $display("[TB] FAIL wrap.tile_count got %0d want 1", tileQ.size()); end
        if (tileQ.size() == 1) begin
            checks++; if (tileQ[0] !== expTile(24'hFFFFFC, 8)) begin errors++; $display("[TB] FAIL wrap.tile got %h want %h", tileQ[0], expTile(24'hFFFFFC, 8)); end
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        int badIdle;
        @(posedge clk); #1;
        valid_in = 1'b1; dram_addr = 24'h000000; length = 16'd96;
        mem_valid = 1'b1; tile_ready = 1'b1;
        found = 0;
        for (int cyc = 0; cyc < 100 && !found; cyc++) begin
            @(posedge clk); #1;
            valid_in = 1'b0;
            @(negedge clk);
            if (mem_req && tile_idx == 16'd1 && mem_addr == 24'h000028) found = 1;
        end
        checks++; if (!found) begin errors++; $display("[TB] FAIL rstmid.reach_tile1 got 0 want 1"); end
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || mem_req !== 1'b0 || tile_valid !== 1'b0 || done !== 1'b0 || tile_last !== 1'b0) begin
            errors++; $display("[TB] FAIL rstmid.flags got busy=%b req=%b tv=%b d=%b tl=%b want 0", busy, mem_req, tile_valid, done, tile_last); end
        checks++; if (mem_addr !== '0 || tile_idx !== '0 || flatten() !== '0) begin
            errors++; $display("[TB] FAIL rstmid.regs got addr=%h idx=%0d data=%h want 0", mem_addr, tile_idx, flatten()); end
        badIdle = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (mem_req || busy || tile_valid) badIdle++;
        end
        checks++; if (badIdle != 0) begin errors++; $display("[TB] FAIL rstmid.late_mem_valid got %0d active cycles want 0", badIdle); end
        mem_valid = 1'b0;
        runTransfer(24'h000200, 16'd32, 0, 0, 50);
        checks++; if (doneCyc != 10 || reqQ.size() != 8) begin errors++; $display("[TB] FAIL rstmid.fresh_timing got done=%0d reqs=%0d want 10/8", doneCyc, reqQ.size()); end
        checks++; if (tileQ.size() != 1) begin errors++; $display("[TB] FAIL rstmid.fresh_tiles got %0d want 1", tileQ.size()); end
        if (tileQ.size() == 1) begin
            checks++; if (tileQ[0] !== expTile(24'h000200, 32)) begin errors++; $display("[TB] FAIL rstmid.fresh_tile got %h want %h", tileQ[0], expTile(24'h000200, 32)); end
        end
    endtask

    initial begin
        test_reset();
        test_single_tile();
        test_partial_tile();
        test_zero_length();
        test_backpressure();
        test_addr_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
